// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the RV32 multi-cycle core: FSM state codes and base opcodes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FAULT     = 3'd7
    } state_t;

    // RV32I base opcodes, kept in step with the instruction decoder
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic is_request_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMORY);
    endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Counts consecutive un-acked request cycles; flags expiry in request cycle MEM_TIMEOUT.
// Latency: combinational expired; counter updates on the clock edge.
// Backpressure: none; an ack in the limit cycle wins over expiry. MEM_TIMEOUT=0 disables.
module ack_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic start,
    input  logic req,
    input  logic ack,
    output logic expired
);

    localparam bit          ENABLE = (MEM_TIMEOUT != 0);
    localparam int unsigned LIMIT  = ENABLE ? MEM_TIMEOUT - 1 : 0;
    localparam int unsigned W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    // cnt holds the number of earlier request cycles that went without ack
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (start) begin
            cnt <= '0;
        end else if (req && !ack && (cnt != W'(LIMIT))) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = ENABLE && req && !ack && (cnt == W'(LIMIT));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback with one-cycle strobes.
// Latency: 4 cycles ALU, 3 execute-retire, plus memory wait cycles; retire count lags one cycle.
// Backpressure: holds IMEM/DMEM requests until ack; watchdog expiry parks the core in FAULT.
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IMEM_ACK,
    input  logic             DMEM_ACK,
    input  logic             WREG,
    input  logic             WMEM,
    input  logic             RMEM,
    input  logic             BRANCH,
    input  logic             BR_TAKEN,
    input  logic             ILLEGAL,
    output logic             IMEM_REQ,
    output logic             DMEM_REQ,
    output logic             DMEM_WE,
    output logic             IR_LOAD,
    output logic             PC_INC,
    output logic             PC_BRANCH,
    output logic             REG_WE,
    output logic             HALTED,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] INSTR_COUNT
);

    state_t state, state_nxt;
    logic wreg_q, wmem_q, rmem_q, branch_q, taken_q;
    logic [CNT_W-1:0] instr_cnt;

    logic imem_req_c, dmem_req_c, dmem_we_c, ir_load_c, reg_we_c, halted_c;
    logic retire, taken_now;
    logic wd_start, wd_req, wd_ack, wd_expired;

    // watchdog inputs come straight from the state register to keep the next-state logic acyclic
    assign wd_req   = is_request_state(state);
    assign wd_ack   = (state == S_FETCH) ? IMEM_ACK : DMEM_ACK;
    assign wd_start = RST || ((state_nxt != state) && is_request_state(state_nxt));

    ack_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
        .clk     (CLK),
        .start   (wd_start),
        .req     (wd_req),
        .ack     (wd_ack),
        .expired (wd_expired)
    );

    always_comb begin
        state_nxt  = state;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_load_c  = 1'b0;
        reg_we_c   = 1'b0;
        halted_c   = 1'b0;
        retire     = 1'b0;
        taken_now  = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (IMEM_ACK) begin
                    ir_load_c = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wd_expired) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                if (ILLEGAL || (WMEM && RMEM)) state_nxt = S_FAULT;
                else                           state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                taken_now = branch_q && BR_TAKEN;
                if (wmem_q || rmem_q) begin
                    state_nxt = S_MEMORY;
                end else if (wreg_q) begin
                    state_nxt = S_WRITEBACK;
                end else begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_MEMORY: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = wmem_q;
                taken_now  = taken_q;
                if (DMEM_ACK) begin
                    if (rmem_q) begin
                        state_nxt = S_WRITEBACK;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (wd_expired) begin
                    state_nxt = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                reg_we_c  = 1'b1;
                taken_now = taken_q;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_FAULT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_nxt = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_FETCH;
            wreg_q    <= 1'b0;
            wmem_q    <= 1'b0;
            rmem_q    <= 1'b0;
            branch_q  <= 1'b0;
            taken_q   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE && state_nxt == S_EXECUTE) begin
                wreg_q   <= WREG;
                wmem_q   <= WMEM;
                rmem_q   <= RMEM;
                branch_q <= BRANCH;
            end
            if (state == S_EXECUTE) taken_q <= branch_q && BR_TAKEN;
            if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    // reset forces every output low, including mid-request
    assign IMEM_REQ    = imem_req_c && !RST;
    assign DMEM_REQ    = dmem_req_c && !RST;
    assign DMEM_WE     = dmem_we_c && !RST;
    assign IR_LOAD     = ir_load_c && !RST;
    assign PC_INC      = retire && !taken_now && !RST;
    assign PC_BRANCH   = retire && taken_now && !RST;
    assign REG_WE      = reg_we_c && !RST;
    assign HALTED      = halted_c && !RST;
    assign STATE       = RST ? 3'd0 : state;
    assign INSTR_COUNT = RST ? '0 : instr_cnt;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized instruction-level bench: each instruction is expanded into its expected cycle trace.
module tb_multicycle_sequencer;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 8;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_BRW = 4,
                   K_NOP = 5, K_ILL = 6, K_BOTH = 7;

    typedef struct packed {
        logic       imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_branch, reg_we, halted;
        logic [2:0] state;
    } obs_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic IMEM_ACK = 1'b0, DMEM_ACK = 1'b0, WREG = 1'b0, WMEM = 1'b0, RMEM = 1'b0;
    logic BRANCH = 1'b0, BR_TAKEN = 1'b0, ILLEGAL = 1'b0;
    logic IMEM_REQ, DMEM_REQ, DMEM_WE, IR_LOAD, PC_INC, PC_BRANCH, REG_WE, HALTED;
    logic [2:0]    STATE;
    logic [CW-1:0] INSTR_COUNT;

    int n_chk  = 0;
    int n_fail = 0;
    logic [CW-1:0] exp_count = '0;

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .IMEM_ACK(IMEM_ACK), .DMEM_ACK(DMEM_ACK),
        .WREG(WREG), .WMEM(WMEM), .RMEM(RMEM), .BRANCH(BRANCH), .BR_TAKEN(BR_TAKEN),
        .ILLEGAL(ILLEGAL), .IMEM_REQ(IMEM_REQ), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
        .IR_LOAD(IR_LOAD), .PC_INC(PC_INC), .PC_BRANCH(PC_BRANCH), .REG_WE(REG_WE),
        .HALTED(HALTED), .STATE(STATE), .INSTR_COUNT(INSTR_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // don't-care inputs get noise so ignored acks and stale decoder flags are exercised
    task automatic rand_inputs();
        RST      = 1'b0;
        IMEM_ACK = 1'($urandom_range(0, 1));
        DMEM_ACK = 1'($urandom_range(0, 1));
        WREG     = 1'($urandom_range(0, 1));
        WMEM     = 1'($urandom_range(0, 1));
        RMEM     = 1'($urandom_range(0, 1));
        BRANCH   = 1'($urandom_range(0, 1));
        BR_TAKEN = 1'($urandom_range(0, 1));
        ILLEGAL  = 1'($urandom_range(0, 1));
    endtask

    // inputs are already applied; compare at the falling edge, advance the model after the rising edge
    task automatic cycle(input string tag, input obs_t want, input bit retire);
        obs_t got;
        @(negedge CLK);
        got = {IMEM_REQ, DMEM_REQ, DMEM_WE, IR_LOAD, PC_INC, PC_BRANCH, REG_WE, HALTED, STATE};
        chk($sformatf("%s.out", tag), 32'(got), 32'(want));
        chk($sformatf("%s.cnt", tag), 32'(INSTR_COUNT), RST ? 32'd0 : 32'(exp_count));
        @(posedge CLK);
        #1;
        if (RST) exp_count = '0;
        else if (retire) exp_count = exp_count + 1'b1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            RST = 1'b1;
            cycle("reset", '0, 1'b0);
        end
        RST = 1'b0;
    endtask

    task automatic fault_hold();
        obs_t e;
        e = '0;
        e.halted = 1'b1;
        e.state  = 3'd7;
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            cycle("fault", e, 1'b0);
        end
        do_reset();
    endtask

    // fd/md: request cycle carrying the ack (0 = never); rm: memory cycle that gets RST (0 = none)
    task automatic run_instr(input int kind, input bit taken, input int fd, input int md, input int rm);
        obs_t e;
        bit wreg, wmem, rmem, br, ill, jump;
        wreg = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_BRW);
        wmem = (kind == K_STORE) || (kind == K_BOTH);
        rmem = (kind == K_LOAD) || (kind == K_BOTH);
        br   = (kind == K_BR) || (kind == K_BRW);
        ill  = (kind == K_ILL);
        jump = br && taken;

        for (int i = 1; i <= int'(TO); i++) begin
            rand_inputs();
            IMEM_ACK = (i == fd);
            e = '0;
            e.imem_req = 1'b1;
            e.ir_load  = (i == fd);
            cycle("fetch", e, 1'b0);
            if (i == fd) break;
        end
        if (fd == 0) begin
            fault_hold();
            return;
        end

        rand_inputs();
        {WREG, WMEM, RMEM, BRANCH, ILLEGAL} = {wreg, wmem, rmem, br, ill};
        e = '0;
        e.state = 3'd1;
        cycle("decode", e, 1'b0);
        if (ill || (wmem && rmem)) begin
            fault_hold();
            return;
        end

        rand_inputs();
        BR_TAKEN = taken;
        e = '0;
        e.state = 3'd2;
        if (!wmem && !rmem && !wreg) begin
            e.pc_branch = jump;
            e.pc_inc    = !jump;
            cycle("execute", e, 1'b1);
            return;
        end
        cycle("execute", e, 1'b0);

        if (wmem || rmem) begin
            for (int j = 1; j <= int'(TO); j++) begin
                rand_inputs();
                if (j == rm) begin
                    RST = 1'b1;
                    cycle("mem_reset", '0, 1'b0);
                    RST = 1'b0;
                    return;
                end
                DMEM_ACK = (j == md);
                e = '0;
                e.state    = 3'd3;
                e.dmem_req = 1'b1;
                e.dmem_we  = wmem;
                if (j == md && wmem) begin
                    e.pc_branch = jump;
                    e.pc_inc    = !jump;
                end
                cycle("memory", e, (j == md) && wmem);
                if (j == md) break;
            end
            if (md == 0) begin
                fault_hold();
                return;
            end
            if (wmem) return;
        end

        rand_inputs();
        e = '0;
        e.state     = 3'd4;
        e.reg_we    = 1'b1;
        e.pc_branch = jump;
        e.pc_inc    = !jump;
        cycle("writeback", e, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        @(posedge CLK);
        #1;
        do_reset();

        run_instr(K_ALU,   1'b0, 1, 0, 0);
        run_instr(K_LOAD,  1'b0, 1, 3, 0);
        run_instr(K_STORE, 1'b0, 2, 1, 0);
        run_instr(K_BR,    1'b1, 1, 0, 0);
        run_instr(K_BR,    1'b0, 1, 0, 0);
        run_instr(K_BRW,   1'b1, 3, 0, 0);
        run_instr(K_ALU,   1'b0, 0, 0, 0);
        run_instr(K_ALU,   1'b0, int'(TO), 0, 0);
        run_instr(K_LOAD,  1'b0, 1, int'(TO), 0);
        run_instr(K_STORE, 1'b0, 1, 0, 0);
        run_instr(K_LOAD,  1'b0, 1, int'(TO), 2);
        run_instr(K_NOP,   1'b1, 1, 0, 0);
        run_instr(K_ILL,   1'b0, 1, 0, 0);
        run_instr(K_BOTH,  1'b0, 2, 0, 0);

        for (int n = 0; n < 300; n++) begin
            int r, k, fd, md, rm;
            r  = int'($urandom_range(0, 19));
            k  = (r < 5) ? K_ALU : (r < 8) ? K_LOAD : (r < 11) ? K_STORE : (r < 14) ? K_BR :
                 (r < 16) ? K_BRW : (r < 18) ? K_NOP : (r == 18) ? K_ILL : K_BOTH;
            fd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
            md = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
            rm = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, TO)) : 0;
            run_instr(k, 1'($urandom_range(0, 1)), fd, md, rm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
